// File: rtl/ofs_plat_utils_ccip_credit_pkg.sv
// Shared types for the CCI-P request credit gate: request channel views,
// per-channel throttle state and the c0 line-count helper.
package ofs_plat_utils_ccip_credit_pkg;

    typedef struct packed {
        logic       valid;
        logic [1:0] cl_len;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic       valid;
        logic [1:0] cl_len;
    } t_if_ccip_c1_Tx;

    typedef enum logic {
        CREDIT_THROTTLED = 1'b0,
        CREDIT_OPEN      = 1'b1
    } t_credit_state;

    // A c0 read returns cl_len+1 lines
    function automatic logic [2:0] c0_req_lines(input t_if_ccip_c0_Tx tx);
        return tx.valid ? (3'(tx.cl_len) + 3'd1) : 3'd0;
    endfunction

endpackage

// File: rtl/ofs_plat_utils_ccip_credit_chan.sv
// One channel of the credit gate: projects occupancy from the outstanding
// counter plus requests the counter has not absorbed yet, and throttles.
//
// state            | meaning
// CREDIT_THROTTLED | almost-full asserted, waiting for projection <= LO
// CREDIT_OPEN      | requests allowed until projection exceeds HI
module ofs_plat_utils_ccip_credit_chan
    import ofs_plat_utils_ccip_credit_pkg::*;
#(
    parameter int RADIX    = 10,
    parameter int CAPACITY = 512,
    parameter int RESERVE  = 32,
    parameter int HYST     = 16,
    parameter int CNT_LAT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       issue,
    input  logic [RADIX-1:0] cnt,
    output logic             almfull,
    output logic             err
);

    localparam int HI = CAPACITY - RESERVE;
    localparam int LO = HI - HYST;
    localparam int HD = (CNT_LAT > 1) ? CNT_LAT - 1 : 1;

    localparam logic [RADIX:0] HI_V  = (RADIX+1)'(HI);
    localparam logic [RADIX:0] LO_V  = (RADIX+1)'(LO);
    localparam logic [RADIX:0] CAP_V = (RADIX+1)'(CAPACITY);

    if (CAPACITY > 2**RADIX - 1) begin : g_bad_capacity
        $error("credit_chan: CAPACITY does not fit in the counter width");
    end
    if (RESERVE >= CAPACITY) begin : g_bad_reserve
        $error("credit_chan: reserve must be below capacity");
    end
    if (HYST > CAPACITY - RESERVE) begin : g_bad_hyst
        $error("credit_chan: hysteresis larger than the throttle threshold");
    end
    if (CNT_LAT < 1) begin : g_bad_lat
        $error("credit_chan: CNT_LAT must be at least 1");
    end

    t_credit_state    state_q, state_d;
    logic             err_q, err_d;
    logic [2:0]       hist_q [HD];
    logic [2:0]       hist_d [HD];
    logic [RADIX:0]   proj;

    // The window is this cycle's issue plus the CNT_LAT-1 previous ones;
    // anything older is already visible in cnt.
    always_comb begin
        proj = (RADIX+1)'(cnt) + (RADIX+1)'(issue);
        for (int i = 0; i < CNT_LAT - 1; i++) begin
            proj = proj + (RADIX+1)'(hist_q[i]);
        end

        hist_d[0] = issue;
        for (int i = 1; i < HD; i++) begin
            hist_d[i] = hist_q[i-1];
        end

        state_d = state_q;
        case (state_q)
            CREDIT_THROTTLED: if (proj <= LO_V) state_d = CREDIT_OPEN;
            CREDIT_OPEN:      if (proj > HI_V)  state_d = CREDIT_THROTTLED;
            default:          state_d = CREDIT_THROTTLED;
        endcase

        err_d = err_q | (proj > CAP_V);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CREDIT_THROTTLED;
            err_q   <= 1'b0;
            hist_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
        end
    end

    assign almfull = (state_q == CREDIT_THROTTLED);
    assign err     = err_q;

endmodule

// File: rtl/ofs_plat_utils_ccip_req_credit_gate.sv
// Per-channel almost-full back-pressure derived from the c0/c1 outstanding
// counters, with sticky capacity-violation flags.
module ofs_plat_utils_ccip_req_credit_gate
    import ofs_plat_utils_ccip_credit_pkg::*;
#(
    parameter int C0RX_DEPTH_RADIX = 10,
    parameter int C1RX_DEPTH_RADIX = 10,
    parameter int C0_CAPACITY      = 512,
    parameter int C1_CAPACITY      = 512,
    parameter int ALMFULL_SLACK    = 8,
    parameter int HYST             = 16,
    parameter int CNT_LAT          = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  t_if_ccip_c0_Tx              c0Tx,
    input  t_if_ccip_c1_Tx              c1Tx,
    input  logic [C0RX_DEPTH_RADIX-1:0] c0_cnt,
    input  logic [C1RX_DEPTH_RADIX-1:0] c1_cnt,
    output logic                        c0TxAlmFull,
    output logic                        c1TxAlmFull,
    output logic                        c0_overflow_err,
    output logic                        c1_overflow_err
);

    // Reads can be up to 4 lines each, so c0 reserves 4 lines per slack request
    localparam int C0_RESERVE = 4 * ALMFULL_SLACK;
    localparam int C1_RESERVE = ALMFULL_SLACK;

    logic [2:0] c0_issue;
    logic [2:0] c1_issue;
    logic       unused_c1_len;

    // Multi-line writes still produce a single write response
    assign c0_issue      = c0_req_lines(c0Tx);
    assign c1_issue      = {2'b00, c1Tx.valid};
    assign unused_c1_len = ^c1Tx.cl_len;

    ofs_plat_utils_ccip_credit_chan #(
        .RADIX    (C0RX_DEPTH_RADIX),
        .CAPACITY (C0_CAPACITY),
        .RESERVE  (C0_RESERVE),
        .HYST     (HYST),
        .CNT_LAT  (CNT_LAT)
    ) u_c0 (
        .clk     (clk),
        .reset   (reset),
        .issue   (c0_issue),
        .cnt     (c0_cnt),
        .almfull (c0TxAlmFull),
        .err     (c0_overflow_err)
    );

    ofs_plat_utils_ccip_credit_chan #(
        .RADIX    (C1RX_DEPTH_RADIX),
        .CAPACITY (C1_CAPACITY),
        .RESERVE  (C1_RESERVE),
        .HYST     (HYST),
        .CNT_LAT  (CNT_LAT)
    ) u_c1 (
        .clk     (clk),
        .reset   (reset),
        .issue   (c1_issue),
        .cnt     (c1_cnt),
        .almfull (c1TxAlmFull),
        .err     (c1_overflow_err)
    );

endmodule

// File: tb/tb_ofs_plat_utils_ccip_req_credit_gate.sv
// Bench for the CCI-P request credit gate: occupancy-projection model checked
// every cycle, directed boundary vectors, and throttled random traffic.
module tb_ofs_plat_utils_ccip_req_credit_gate;
    import ofs_plat_utils_ccip_credit_pkg::*;

    localparam int CAP0  = 512;
    localparam int CAP1  = 512;
    localparam int SLACK = 8;
    localparam int HYSTV = 16;
    localparam int LAT   = 2;
    localparam int HI0   = CAP0 - 4 * SLACK;
    localparam int LO0   = HI0 - HYSTV;
    localparam int HI1   = CAP1 - SLACK;
    localparam int LO1   = HI1 - HYSTV;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    t_if_ccip_c0_Tx c0Tx;
    t_if_ccip_c1_Tx c1Tx;
    logic [9:0]     c0_cnt;
    logic [9:0]     c1_cnt;
    logic           c0TxAlmFull, c1TxAlmFull, c0_overflow_err, c1_overflow_err;

    int tests = 0;
    int fails = 0;

    ofs_plat_utils_ccip_req_credit_gate dut (
        .clk             (clk),
        .reset           (reset),
        .c0Tx            (c0Tx),
        .c1Tx            (c1Tx),
        .c0_cnt          (c0_cnt),
        .c1_cnt          (c1_cnt),
        .c0TxAlmFull     (c0TxAlmFull),
        .c1TxAlmFull     (c1TxAlmFull),
        .c0_overflow_err (c0_overflow_err),
        .c1_overflow_err (c1_overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy = counter + every request from the last LAT cycles
    // (including the one being issued now); throttle thresholds HI/LO.
    int  m_thr0 = 1, m_thr1 = 1, m_err0 = 0, m_err1 = 0;
    int  h0[$], h1[$];
    bit  chk_en = 0;

    always @(posedge clk) begin
        int l0, l1, p0, p1;
        l0 = c0Tx.valid ? c0Tx.cl_len + 1 : 0;
        l1 = c1Tx.valid ? 1 : 0;
        if (reset) begin
            m_thr0 = 1; m_thr1 = 1; m_err0 = 0; m_err1 = 0;
            h0.delete(); h1.delete();
            chk_en = 1;
        end else begin
            p0 = int'(c0_cnt) + l0;
            p1 = int'(c1_cnt) + l1;
            foreach (h0[i]) p0 += h0[i];
            foreach (h1[i]) p1 += h1[i];
            if (m_thr0 == 1 && p0 <= LO0) m_thr0 = 0;
            else if (m_thr0 == 0 && p0 > HI0) m_thr0 = 1;
            if (m_thr1 == 1 && p1 <= LO1) m_thr1 = 0;
            else if (m_thr1 == 0 && p1 > HI1) m_thr1 = 1;
            if (p0 > CAP0) m_err0 = 1;
            if (p1 > CAP1) m_err1 = 1;
            h0.push_front(l0);
            h1.push_front(l1);
            if (h0.size() > LAT - 1) void'(h0.pop_back());
            if (h1.size() > LAT - 1) void'(h1.pop_back());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_c0_almfull", c0TxAlmFull, m_thr0);
            check("model_c1_almfull", c1TxAlmFull, m_thr1);
            check("model_c0_err", c0_overflow_err, m_err0);
            check("model_c1_err", c1_overflow_err, m_err1);
        end
    end

    int cnt0, cnt1, i0a, i0b, cur0, i1a, i1b, cur1, max0, max1, r;

    initial begin
        c0Tx = '0; c1Tx = '0; c0_cnt = '0; c1_cnt = '0;

        repeat (5) @(negedge clk);
        check("rst_c0_almfull", c0TxAlmFull, 1);
        check("rst_c1_almfull", c1TxAlmFull, 1);
        check("rst_c0_err", c0_overflow_err, 0);
        check("rst_c1_err", c1_overflow_err, 0);
        reset = 1'b0;
        check("post_rst_cyc1_c0", c0TxAlmFull, 1);
        @(negedge clk);
        check("post_rst_cyc2_c0", c0TxAlmFull, 0);
        check("post_rst_cyc2_c1", c1TxAlmFull, 0);

        // c0 in-flight request pushes projection over HI before cnt moves
        c0_cnt = 10'd478;
        @(negedge clk);
        check("c0_478_open", c0TxAlmFull, 0);
        c0Tx.valid = 1'b1; c0Tx.cl_len = 2'd2;
        @(negedge clk);
        check("c0_inflight_throttle", c0TxAlmFull, 1);
        c0Tx = '0;
        @(negedge clk);
        check("c0_inflight_hold", c0TxAlmFull, 1);
        c0_cnt = 10'd481;
        @(negedge clk);
        c0_cnt = 10'd470;
        @(negedge clk);
        check("c0_hyst_470", c0TxAlmFull, 1);
        c0_cnt = 10'd465;
        @(negedge clk);
        check("c0_hyst_465", c0TxAlmFull, 1);
        c0_cnt = 10'd464;
        @(negedge clk);
        check("c0_open_at_lo", c0TxAlmFull, 0);

        // c1 consecutive writes
        c1_cnt = 10'd503;
        @(negedge clk);
        check("c1_503_open", c1TxAlmFull, 0);
        c1Tx.valid = 1'b1;
        @(negedge clk);
        check("c1_at_hi_open", c1TxAlmFull, 0);
        @(negedge clk);
        check("c1_over_hi", c1TxAlmFull, 1);
        c1Tx = '0;
        @(negedge clk);
        check("c1_no_err", c1_overflow_err, 0);
        c1_cnt = '0; c0_cnt = '0;
        repeat (3) @(negedge clk);

        // c0 capacity violation is sticky until reset
        c0_cnt = 10'd510;
        c0Tx.valid = 1'b1; c0Tx.cl_len = 2'd3;
        @(negedge clk);
        check("c0_err_set", c0_overflow_err, 1);
        c0Tx = '0; c0_cnt = '0;
        repeat (4) @(negedge clk);
        check("c0_err_sticky", c0_overflow_err, 1);
        check("c0_open_after_drain", c0TxAlmFull, 0);
        reset = 1'b1;
        @(negedge clk);
        check("c0_err_cleared", c0_overflow_err, 0);
        check("c0_rst_almfull", c0TxAlmFull, 1);
        reset = 1'b0;
        @(negedge clk);

        // Random traffic: AFU honours almost-full, counters lag by LAT cycles
        cnt0 = 0; cnt1 = 0; i0a = 0; i0b = 0; cur0 = 0; i1a = 0; i1b = 0; cur1 = 0;
        max0 = 0; max1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i >= 1500 && i < 1502) begin
                reset = 1'b1;
                cnt0 = 0; cnt1 = 0; i0a = 0; i0b = 0; cur0 = 0; i1a = 0; i1b = 0; cur1 = 0;
                c0Tx = '0; c1Tx = '0;
            end else begin
                reset = 1'b0;
                i0b = i0a; i0a = cur0;
                i1b = i1a; i1a = cur1;
                r = $urandom_range(0, 2);
                if (r > cnt0) r = cnt0;
                cnt0 = cnt0 + i0b - r;
                r = $urandom_range(0, 1);
                if (r > cnt1) r = cnt1;
                cnt1 = cnt1 + i1b - r;
                c0Tx = '0; c1Tx = '0; cur0 = 0; cur1 = 0;
                if (!c0TxAlmFull && $urandom_range(0, 3) != 0) begin
                    c0Tx.valid = 1'b1;
                    c0Tx.cl_len = 2'($urandom_range(0, 3));
                    cur0 = c0Tx.cl_len + 1;
                end
                if (!c1TxAlmFull && $urandom_range(0, 3) != 0) begin
                    c1Tx.valid = 1'b1;
                    c1Tx.cl_len = 2'($urandom_range(0, 3));
                    cur1 = 1;
                end
            end
            c0_cnt = 10'(cnt0);
            c1_cnt = 10'(cnt1);
            if (cnt0 > max0) max0 = cnt0;
            if (cnt1 > max1) max1 = cnt1;
            @(negedge clk);
        end
        check("rand_c0_no_buffer_overflow", (max0 <= CAP0) ? 1 : 0, 1);
        check("rand_c1_no_buffer_overflow", (max1 <= CAP1) ? 1 : 0, 1);
        check("rand_c0_reached_throttle", (max0 > LO0) ? 1 : 0, 1);
        check("rand_c0_err_clear", c0_overflow_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
